// File: rtl/axicb_mst_switch_if.sv
// Channel bundle for NB parallel AXI-like lanes; B/R payloads and rlast are shared by all lanes.
interface axicb_mst_switch_if #(
    parameter int unsigned NB     = 1,
    parameter int unsigned AWCH_W = 8,
    parameter int unsigned WCH_W  = 8,
    parameter int unsigned BCH_W  = 8,
    parameter int unsigned ARCH_W = 8,
    parameter int unsigned RCH_W  = 8
);
    logic [NB-1:0]        awvalid;
    logic [NB-1:0]        awready;
    logic [NB*AWCH_W-1:0] awch;
    logic [NB-1:0]        wvalid;
    logic [NB-1:0]        wready;
    logic [NB-1:0]        wlast;
    logic [NB*WCH_W-1:0]  wch;
    logic [NB-1:0]        bvalid;
    logic [NB-1:0]        bready;
    logic [BCH_W-1:0]     bch;
    logic [NB-1:0]        arvalid;
    logic [NB-1:0]        arready;
    logic [NB*ARCH_W-1:0] arch;
    logic [NB-1:0]        rvalid;
    logic [NB-1:0]        rready;
    logic                 rlast;
    logic [RCH_W-1:0]     rch;

    modport master (
        output awvalid, awch, wvalid, wlast, wch, bready, arvalid, arch, rready,
        input  awready, wready, bvalid, bch, arready, rvalid, rlast, rch
    );

    modport slave (
        input  awvalid, awch, wvalid, wlast, wch, bready, arvalid, arch, rready,
        output awready, wready, bvalid, bch, arready, rvalid, rlast, rch
    );
endinterface

// File: rtl/axicb_mst_switch.sv
// Crossbar slave-side switch: round-robin merge of MST_NB masters onto one slave port,
// with in-order index FIFOs steering W beats and routing B/R responses back.
module axicb_mst_switch #(
    parameter int unsigned MST_NB     = 4,
    parameter int unsigned OSTDREQ_NB = 4,
    parameter int unsigned AWCH_W     = 8,
    parameter int unsigned WCH_W      = 8,
    parameter int unsigned BCH_W      = 8,
    parameter int unsigned ARCH_W     = 8,
    parameter int unsigned RCH_W      = 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    axicb_mst_switch_if.slave         i_bus,
    axicb_mst_switch_if.master        o_bus
);
    localparam int unsigned IW  = (MST_NB > 1) ? $clog2(MST_NB) : 1;
    localparam int unsigned AD  = (OSTDREQ_NB > 1) ? $clog2(OSTDREQ_NB) : 1;
    localparam int unsigned PW  = AD + 1;
    localparam int unsigned F_W = 0;
    localparam int unsigned F_B = 1;
    localparam int unsigned F_R = 2;

    logic [IW-1:0] aw_ptr_q, aw_ptr_d, aw_lidx_q, aw_lidx_d, aw_grant;
    logic          aw_lock_q, aw_lock_d, aw_stall, aw_hs;
    logic [IW-1:0] ar_ptr_q, ar_ptr_d, ar_lidx_q, ar_lidx_d, ar_grant;
    logic          ar_lock_q, ar_lock_d, ar_stall, ar_hs;

    logic [IW-1:0] fifo_mem_q [3][OSTDREQ_NB];
    logic [PW-1:0] wp_q [3];
    logic [PW-1:0] rp_q [3];
    logic [PW-1:0] wp_d [3];
    logic [PW-1:0] rp_d [3];
    logic [IW-1:0] head [3];
    logic [2:0]    push, pop, full, empty;

    function automatic logic [IW-1:0] rr_pick(input logic [MST_NB-1:0] req,
                                              input logic [IW-1:0]     ptr);
        logic [IW-1:0] g;
        int            idx;
        g = ptr;
        // Scan downward so the closest requester at/after ptr is the last one kept
        for (int i = int'(MST_NB) - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % int'(MST_NB);
            if (req[IW'(idx)]) g = IW'(idx);
        end
        return g;
    endfunction

    // Index FIFO status (W, B, R)
    always_comb begin
        for (int f = 0; f < 3; f++) begin
            empty[f] = (wp_q[f] == rp_q[f]);
            full[f]  = ((wp_q[f] - rp_q[f]) == PW'(OSTDREQ_NB));
            head[f]  = fifo_mem_q[f][rp_q[f][AD-1:0]];
        end
    end

    always_comb begin
        for (int f = 0; f < 3; f++) begin
            wp_d[f] = wp_q[f] + PW'(push[f]);
            rp_d[f] = rp_q[f] + PW'(pop[f]);
        end
    end

    // AW arbiter: grant held while the slave back-pressures a presented request
    always_comb begin
        aw_grant      = aw_lock_q ? aw_lidx_q : rr_pick(i_bus.awvalid, aw_ptr_q);
        aw_stall      = full[F_W] | full[F_B] | ~aresetn;
        o_bus.awvalid = '0;
        o_bus.awch    = '0;
        i_bus.awready = '0;
        for (int k = 0; k < int'(MST_NB); k++) begin
            if (aw_grant == IW'(k)) begin
                o_bus.awvalid    = i_bus.awvalid[k] & ~aw_stall;
                o_bus.awch       = i_bus.awch[k*AWCH_W +: AWCH_W];
                i_bus.awready[k] = o_bus.awready[0] & ~aw_stall;
            end
        end
        aw_hs     = o_bus.awvalid[0] & o_bus.awready[0];
        aw_ptr_d  = aw_ptr_q;
        aw_lock_d = aw_lock_q;
        aw_lidx_d = aw_lidx_q;
        if (aw_hs) begin
            aw_lock_d = 1'b0;
            aw_ptr_d  = (aw_grant == IW'(MST_NB - 1)) ? '0 : aw_grant + IW'(1);
        end else if (o_bus.awvalid[0]) begin
            aw_lock_d = 1'b1;
            aw_lidx_d = aw_grant;
        end
    end

    // AR arbiter, independent of AW
    always_comb begin
        ar_grant      = ar_lock_q ? ar_lidx_q : rr_pick(i_bus.arvalid, ar_ptr_q);
        ar_stall      = full[F_R] | ~aresetn;
        o_bus.arvalid = '0;
        o_bus.arch    = '0;
        i_bus.arready = '0;
        for (int k = 0; k < int'(MST_NB); k++) begin
            if (ar_grant == IW'(k)) begin
                o_bus.arvalid    = i_bus.arvalid[k] & ~ar_stall;
                o_bus.arch       = i_bus.arch[k*ARCH_W +: ARCH_W];
                i_bus.arready[k] = o_bus.arready[0] & ~ar_stall;
            end
        end
        ar_hs     = o_bus.arvalid[0] & o_bus.arready[0];
        ar_ptr_d  = ar_ptr_q;
        ar_lock_d = ar_lock_q;
        ar_lidx_d = ar_lidx_q;
        if (ar_hs) begin
            ar_lock_d = 1'b0;
            ar_ptr_d  = (ar_grant == IW'(MST_NB - 1)) ? '0 : ar_grant + IW'(1);
        end else if (o_bus.arvalid[0]) begin
            ar_lock_d = 1'b1;
            ar_lidx_d = ar_grant;
        end
    end

    // W steering and B/R return routing by FIFO head
    always_comb begin
        o_bus.wvalid = '0;
        o_bus.wlast  = '0;
        o_bus.wch    = '0;
        i_bus.wready = '0;
        i_bus.bvalid = '0;
        o_bus.bready = '0;
        i_bus.rvalid = '0;
        o_bus.rready = '0;
        for (int k = 0; k < int'(MST_NB); k++) begin
            if (!empty[F_W] && head[F_W] == IW'(k)) begin
                o_bus.wvalid    = i_bus.wvalid[k];
                o_bus.wlast     = i_bus.wlast[k];
                o_bus.wch       = i_bus.wch[k*WCH_W +: WCH_W];
                i_bus.wready[k] = o_bus.wready[0];
            end
            if (!empty[F_B] && head[F_B] == IW'(k)) begin
                i_bus.bvalid[k] = o_bus.bvalid[0];
                o_bus.bready    = i_bus.bready[k];
            end
            if (!empty[F_R] && head[F_R] == IW'(k)) begin
                i_bus.rvalid[k] = o_bus.rvalid[0];
                o_bus.rready    = i_bus.rready[k];
            end
        end
        i_bus.bch   = o_bus.bch;
        i_bus.rch   = o_bus.rch;
        i_bus.rlast = o_bus.rlast;
        push        = {ar_hs, aw_hs, aw_hs};
        pop         = {o_bus.rvalid[0] & o_bus.rready[0] & o_bus.rlast,
                       o_bus.bvalid[0] & o_bus.bready[0],
                       o_bus.wvalid[0] & o_bus.wready[0] & o_bus.wlast[0]};
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_ptr_q  <= '0;
            aw_lock_q <= 1'b0;
            aw_lidx_q <= '0;
            ar_ptr_q  <= '0;
            ar_lock_q <= 1'b0;
            ar_lidx_q <= '0;
            for (int f = 0; f < 3; f++) begin
                wp_q[f] <= '0;
                rp_q[f] <= '0;
            end
        end else begin
            aw_ptr_q  <= aw_ptr_d;
            aw_lock_q <= aw_lock_d;
            aw_lidx_q <= aw_lidx_d;
            ar_ptr_q  <= ar_ptr_d;
            ar_lock_q <= ar_lock_d;
            ar_lidx_q <= ar_lidx_d;
            for (int f = 0; f < 3; f++) begin
                wp_q[f] <= wp_d[f];
                rp_q[f] <= rp_d[f];
            end
        end
    end

    // Storage carries no reset; pointers alone define occupancy
    always_ff @(posedge aclk) begin
        if (push[F_W]) fifo_mem_q[F_W][wp_q[F_W][AD-1:0]] <= aw_grant;
        if (push[F_B]) fifo_mem_q[F_B][wp_q[F_B][AD-1:0]] <= aw_grant;
        if (push[F_R]) fifo_mem_q[F_R][wp_q[F_R][AD-1:0]] <= ar_grant;
    end
endmodule

// File: doc/axicb_mst_switch.md
Name: axicb_mst_switch

Overview:
- Slave-side switch of the crossbar: merges MST_NB master interfaces onto one slave interface. It is the converging counterpart of the per-master fan-out switch.
- AW and AR are granted by independent round-robin arbiters.
- W beats are steered by an in-order write-grant FIFO.
- B and R responses are routed back to the originating master by in-order tracking FIFOs. The downstream slave returns responses in request order.

Parameters:
- MST_NB, 4, number of masters (2..4)
- OSTDREQ_NB, 4, depth of each tracking FIFO (max outstanding requests per channel, power of 2)
- AWCH_W, 8, AW payload width
- WCH_W, 8, W payload width
- BCH_W, 8, B payload width
- ARCH_W, 8, AR payload width
- RCH_W, 8, R payload width

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- i_awvalid/i_awready  in/out  MST_NB  AW handshake per master
- i_awch  in  MST_NB*AWCH_W  AW payload, master k at [k*AWCH_W+:AWCH_W]
- i_wvalid/i_wready  in/out  MST_NB  W handshake
- i_wlast  in  MST_NB  W last
- i_wch  in  MST_NB*WCH_W  W payload
- i_bvalid/i_bready  out/in  MST_NB  B handshake
- i_bch  out  BCH_W  B payload, broadcast to all masters
- i_arvalid/i_arready  in/out  MST_NB  AR handshake
- i_arch  in  MST_NB*ARCH_W  AR payload
- i_rvalid/i_rready  out/in  MST_NB  R handshake
- i_rlast  out  1  R last, broadcast
- i_rch  out  RCH_W  R payload, broadcast
- o_awvalid/o_awready  out/in  1  AW to slave
- o_awch  out  AWCH_W
- o_wvalid/o_wready  out/in  1
- o_wlast  out  1
- o_wch  out  WCH_W
- o_bvalid/o_bready  in/out  1
- o_bch  in  BCH_W
- o_arvalid/o_arready  out/in  1
- o_arch  out  ARCH_W
- o_rvalid/o_rready  in/out  1
- o_rlast  in  1
- o_rch  in  RCH_W

Behaviour:

Reset (aresetn=0 at a rising edge):
- All FIFOs emptied.
- Both RR pointers point at master 0.
- Grant locks cleared.
- All o_*valid, o_*ready, i_*valid and i_*ready outputs are 0 while the FIFOs are empty.
- Reset mid-burst discards all tracking; upstream and downstream must reset together.

Arbitration (AW, AR identical, independent):
- Grant = first requesting master at or after the pointer, scanning upward with wrap.
- Data path is combinational, zero added latency:
  - o_xvalid = i_xvalid[grant] & ~stall
  - i_xready[grant] = o_xready & ~stall
  - o_xch = payload[grant]
- If o_xvalid=1 and o_xready=0, the grant is locked (registered) until the handshake, so payload stays stable.
- On handshake, pointer <= grant+1 mod MST_NB.
- No requests: o_xvalid=0 and the pointer is unchanged.

Stall conditions:
- AW stalls when the W FIFO or the B FIFO is full.
- AR stalls when the R FIFO is full.
- A pop in the same cycle does not release a full stall.

W routing:
- An AW handshake pushes the grant index into both the W FIFO and the B FIFO.
- W head = h:
  - o_wvalid = i_wvalid[h] & ~wempty
  - i_wready[h] = o_wready & ~wempty
  - o_wch/o_wlast taken from master h
- A handshake with wlast=1 pops the W FIFO.
- W FIFO empty: all i_wready=0. A master's W beats issued before its AW are held.
- AW push and wlast pop in the same cycle leave the count unchanged.

B routing:
- B head = h:
  - i_bvalid[h] = o_bvalid & ~bempty
  - o_bready = i_bready[h] & ~bempty
- A B handshake pops the B FIFO.
- B FIFO empty: o_bready=0 and the response is held, never dropped.

R routing:
- AR handshake pushes into the R FIFO. Head h drives i_rvalid[h] and o_rready.
- Only a handshake with o_rlast=1 pops the R FIFO.
- R FIFO empty: o_rready=0.

Other:
- Non-head masters always see valid=0 and ready=0.
- Index width = $clog2(MST_NB).
- FIFO pointers are one bit wider than the address and wrap modulo 2*OSTDREQ_NB.

Test Plan:
- Reset: aresetn=0 for 3 cycles with all i_awvalid=1 -> o_awvalid=0, all i_awready=0; after release, first grant = master 0.
- Round-robin: masters 0,2,3 hold awvalid and o_awready=1 -> AW grant order 0,2,3,0,2,3.
- Backpressure: o_awready=0 for 4 cycles while master 1 wins and master 0 then raises awvalid -> o_awch stays master 1 payload until the handshake.
- W ordering: AW from masters 2 then 0, 3-beat bursts, master 0 W presented first -> o_wch shows master 2's 3 beats, then master 0's; i_wready[0]=0 during master 2's burst.
- Outstanding limit: OSTDREQ_NB=4, 4 ARs accepted, no R returned -> 5th AR stalled (o_arvalid=0). One R with rlast=1 routed to the first requester -> 5th AR accepted the next cycle.
- Response routing: ARs from masters 1,3, 2-beat R bursts -> i_rvalid[1] for 2 beats, then i_rvalid[3] for 2 beats. An o_bvalid with empty B FIFO keeps o_bready=0.
